// File: rtl/vx_tcu_fedp_sched_pkg.sv
// Shared definitions for the tensor-core FEDP issue/retire scheduler.
package vx_tcu_fedp_sched_pkg;

  localparam int TCU_NUM_FMTS = 4;
  localparam int TCU_LAT_W    = 5;
  localparam int TCU_MAX_LAT  = 8;

  // Source format codes; each selects one latency slice below.
  typedef enum logic [2:0] {
    TCU_FMT_FP32 = 3'd0,
    TCU_FMT_FP16 = 3'd1,
    TCU_FMT_BF16 = 3'd2,
    TCU_FMT_I8   = 3'd3
  } tcu_fmt_e;

  // Packed per-format latency, index 0 in the LSB slice: fp32=8, fp16=6, bf16=6, int8=4.
  localparam logic [TCU_NUM_FMTS*TCU_LAT_W-1:0] TCU_FMT_LATENCY = {5'd4, 5'd6, 5'd6, 5'd8};

  // Layout of the opaque 64-bit metadata carried alongside each op.
  typedef struct packed {
    logic [15:0] uuid;
    logic [7:0]  wid;
    logic [31:0] pc;
    logic [7:0]  rd;
  } tcu_sched_mdata_t;

endpackage

// File: rtl/vx_tcu_fedp_sched_fifo.sv
// Metadata FIFO: power-of-two depth, wrapping pointers, simultaneous push/pop legal when full.
module vx_tcu_fedp_sched_fifo #(
  parameter int DATA_W = 67,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  // Storage write on push.
  // NOTE: the storage array is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  // Occupancy next-state: push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + ADDR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + ADDR_W'(1);
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/vx_tcu_fedp_sched.sv
// FEDP issue/retire scheduler: per-format latency, valid-delay pipe, in-order retirement.
module vx_tcu_fedp_sched
  import vx_tcu_fedp_sched_pkg::*;
#(
  parameter int NUM_FMTS = TCU_NUM_FMTS,
  parameter int FMT_W    = 3,
  parameter int LAT_W    = TCU_LAT_W,
  parameter logic [NUM_FMTS*LAT_W-1:0] FMT_LATENCY = TCU_FMT_LATENCY,
  parameter int MAX_LAT     = TCU_MAX_LAT,
  parameter int MDATA_W     = 64,
  parameter int MDATA_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exe_valid,
  output logic               exe_ready,
  input  logic [FMT_W-1:0]   exe_fmt,
  input  logic [MDATA_W-1:0] exe_mdata,
  output logic               fedp_enable,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FMT_W-1:0]   res_fmt,
  output logic [MDATA_W-1:0] res_mdata,
  output logic               busy,
  output logic [31:0]        perf_order_stalls
);

  localparam int CNT_W = $clog2(MDATA_DEPTH) + 1;

  logic [MAX_LAT-1:0] pipe_q, pipe_d, shifted, slot_mask;
  logic [LAT_W-1:0]   lat;
  logic [31:0]        perf_q;
  logic               issue, retire, order_ok, fifo_full, fifo_empty, fifo_blocked, order_stall;
  logic [CNT_W-1:0]   fifo_count;
  logic [FMT_W+MDATA_W-1:0] fifo_dout;

  // Latency lookup; unknown format codes take the longest latency.
  always_comb begin
    lat = LAT_W'(MAX_LAT);
    for (int i = 0; i < NUM_FMTS; i++) begin
      if (exe_fmt == FMT_W'(i)) lat = FMT_LATENCY[i*LAT_W +: LAT_W];
    end
  end

  assign res_valid   = pipe_q[0];
  assign fedp_enable = ~res_valid | res_ready;
  assign retire      = res_valid & res_ready;
  assign shifted     = fedp_enable ? (pipe_q >> 1) : pipe_q;
  assign slot_mask   = MAX_LAT'(1) << (lat - LAT_W'(1));
  // No older op may complete in or after the new op's slot, otherwise results would reorder.
  assign order_ok    = ((shifted >> (lat - LAT_W'(1))) == '0);
  // A full FIFO still takes a push when the head retires in the same cycle.
  assign fifo_blocked = fifo_full & ~retire;
  assign exe_ready   = reset & fedp_enable & ~fifo_blocked & order_ok;
  assign issue       = exe_valid & exe_ready;
  assign order_stall = exe_valid & fedp_enable & ~fifo_blocked & ~order_ok;

  // Delay-pipe next state: shift when enabled, mark the new op's completion slot.
  always_comb begin
    pipe_d = shifted;
    if (issue) pipe_d = shifted | slot_mask;
  end

  // Pipe and saturating order-stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
      perf_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (order_stall && (perf_q != '1)) perf_q <= perf_q + 32'd1;
    end
  end

  vx_tcu_fedp_sched_fifo #(
    .DATA_W (FMT_W + MDATA_W),
    .DEPTH  (MDATA_DEPTH)
  ) u_mdata_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (issue),
    .pop_i   (retire),
    .data_i  ({exe_fmt, exe_mdata}),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {res_fmt, res_mdata} = fifo_dout;
  assign busy              = (pipe_q != '0) | (fifo_count != '0);
  assign perf_order_stalls = perf_q;

  // Consistency checks between the delay pipe and the metadata FIFO.
  a_retire_nonempty: assert property (@(posedge clk) disable iff (!reset) retire |-> !fifo_empty)
    else $error("retire with empty metadata FIFO");
  a_push_room: assert property (@(posedge clk) disable iff (!reset) (issue && fifo_full) |-> retire)
    else $error("issue into full metadata FIFO without a pop");
  a_head_tracked: assert property (@(posedge clk) disable iff (!reset) pipe_q[0] |-> (fifo_count != '0))
    else $error("result valid with no metadata held");

endmodule

// File: tb/tb_vx_tcu_fedp_sched.sv
// Randomized and directed bench for vx_tcu_fedp_sched against a queue-based reference model.
module tb_vx_tcu_fedp_sched;
  import vx_tcu_fedp_sched_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exe_valid = 1'b0, exe_ready, res_valid, res_ready = 1'b1, fedp_enable, busy;
  logic [2:0]  exe_fmt = 3'd0, res_fmt;
  logic [63:0] exe_mdata = '0, res_mdata;
  logic [31:0] perf_order_stalls;

  logic        d2_exe_valid = 1'b0, d2_exe_ready, d2_res_valid, d2_res_ready = 1'b1, d2_fedp_enable, d2_busy;
  logic [2:0]  d2_exe_fmt = 3'd0, d2_res_fmt;
  logic [63:0] d2_exe_mdata = '0, d2_res_mdata;
  logic [31:0] d2_perf;

  always #5 clk = ~clk;

  vx_tcu_fedp_sched dut (
    .clk(clk), .reset(reset), .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_fmt(exe_fmt),
    .exe_mdata(exe_mdata), .fedp_enable(fedp_enable), .res_valid(res_valid), .res_ready(res_ready),
    .res_fmt(res_fmt), .res_mdata(res_mdata), .busy(busy), .perf_order_stalls(perf_order_stalls)
  );

  vx_tcu_fedp_sched #(.MDATA_DEPTH(4)) dut_d4 (
    .clk(clk), .reset(reset), .exe_valid(d2_exe_valid), .exe_ready(d2_exe_ready), .exe_fmt(d2_exe_fmt),
    .exe_mdata(d2_exe_mdata), .fedp_enable(d2_fedp_enable), .res_valid(d2_res_valid),
    .res_ready(d2_res_ready), .res_fmt(d2_res_fmt), .res_mdata(d2_res_mdata), .busy(d2_busy),
    .perf_order_stalls(d2_perf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: each in-flight op knows how many enabled cycles remain until it is the result.
  typedef struct {
    int          remaining;
    logic [2:0]  fmt;
    logic [63:0] md;
  } op_t;

  op_t model_q[$];
  int  m_perf = 0;
  logic obs_rv, obs_en, last_issue;

  function automatic int lat_of(input logic [2:0] f);
    case (f)
      3'd0: return 8;
      3'd1: return 6;
      3'd2: return 6;
      3'd3: return 4;
      default: return 8;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [2:0] f, input logic [63:0] md, input logic rr);
    bit e_rv, e_en, e_ret, ok, full, e_rdy;
    int l;
    @(negedge clk);
    exe_valid = v; exe_fmt = f; exe_mdata = md; res_ready = rr;
    #1;
    l     = lat_of(f);
    e_rv  = (model_q.size() > 0) && (model_q[0].remaining == 0);
    e_en  = !e_rv || rr;
    e_ret = e_rv && rr;
    ok    = 1'b1;
    for (int i = (e_ret ? 1 : 0); i < model_q.size(); i++) begin
      int r;
      r = e_en ? model_q[i].remaining - 1 : model_q[i].remaining;
      if (r >= l - 1) ok = 1'b0;
    end
    full  = (model_q.size() == DEPTH) && !e_ret;
    e_rdy = e_en && !full && ok;
    check("res_valid", 64'(res_valid), 64'(e_rv));
    check("fedp_enable", 64'(fedp_enable), 64'(e_en));
    check("exe_ready", 64'(exe_ready), 64'(e_rdy));
    check("busy", 64'(busy), 64'(model_q.size() > 0));
    check("perf_order_stalls", 64'(perf_order_stalls), 64'(m_perf));
    if (e_rv) begin
      check("res_fmt", 64'(res_fmt), 64'(model_q[0].fmt));
      check("res_mdata", res_mdata, model_q[0].md);
    end
    obs_rv = res_valid;
    obs_en = fedp_enable;
    last_issue = v && e_rdy;
    @(posedge clk);
    if (v && e_en && !full && !ok) m_perf++;
    if (e_ret) void'(model_q.pop_front());
    if (e_en) foreach (model_q[i]) model_q[i].remaining--;
    if (v && e_rdy) model_q.push_back('{remaining: l - 1, fmt: f, md: md});
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 64'd0, rr);
  endtask

  initial begin
    int base, attempt, accepted;
    logic [63:0] md;

    // Reset state.
    exe_valid = 1'b1;
    #3;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_exe_ready", 64'(exe_ready), 64'd0);
    check("rst_fedp_enable", 64'(fedp_enable), 64'd1);
    check("rst_perf", 64'(perf_order_stalls), 64'd0);
    exe_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Single fp32 op: result exactly 8 cycles later, one cycle wide.
    step(1'b1, TCU_FMT_FP32, 64'h1111_2222_3333_4444, 1'b1);
    check("fp32_issue", 64'(last_issue), 64'd1);
    for (int c = 1; c <= 9; c++) begin
      step(1'b0, 3'd0, 64'd0, 1'b1);
      if (c == 7) check("fp32_not_early", 64'(obs_rv), 64'd0);
      if (c == 8) check("fp32_at_lat", 64'(obs_rv), 64'd1);
    end

    // fp32 then int8: int8 must wait until its slot is past the fp32 completion.
    base = m_perf;
    step(1'b1, TCU_FMT_FP32, 64'hA0, 1'b1);
    attempt = 0;
    for (int a = 1; a <= 20; a++) begin
      step(1'b1, TCU_FMT_I8, 64'hA1, 1'b1);
      if (last_issue) begin attempt = a; break; end
    end
    check("int8_issue_cycle", 64'(attempt), 64'd5);
    #1;
    check("order_stalls", 64'(perf_order_stalls - 32'(base)), 64'd4);
    idle(10, 1'b1);

    // Eight back-to-back fp16 ops.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, TCU_FMT_FP16, 64'hB0 + 64'(i), 1'b1);
      check("b2b_issue", 64'(last_issue), 64'd1);
    end
    idle(10, 1'b1);

    // Consumer stall: pipe freezes with the head result held.
    for (int i = 0; i < 4; i++) step(1'b1, TCU_FMT_FP16, 64'hC0 + 64'(i), 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, TCU_FMT_FP16, 64'hCF, 1'b0);
      check("stall_enable_low", 64'(obs_en), 64'd0);
      check("stall_head_valid", 64'(obs_rv), 64'd1);
    end
    idle(14, 1'b1);
    check("stall_drained", 64'(model_q.size()), 64'd0);

    // Randomized mix, including out-of-range format codes.
    for (int i = 0; i < 600; i++) begin
      md = {$urandom, $urandom};
      step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), md, 1'($urandom_range(0, 3) != 0));
    end
    idle(16, 1'b1);
    check("random_drained", 64'(busy), 64'd0);

    // Asynchronous reset with three ops outstanding and a result held.
    for (int i = 0; i < 3; i++) step(1'b1, TCU_FMT_I8, 64'hD0 + 64'(i), 1'b0);
    idle(3, 1'b0);
    check("pre_reset_valid", 64'(obs_rv), 64'd1);
    @(negedge clk);
    exe_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_res_valid", 64'(res_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_exe_ready", 64'(exe_ready), 64'd0);
    check("async_rst_fedp_enable", 64'(fedp_enable), 64'd1);
    model_q.delete();
    m_perf = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, TCU_FMT_I8, 64'hE0, 1'b1);
    check("post_reset_issue", 64'(last_issue), 64'd1);
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 3'd0, 64'd0, 1'b1);
      if (c == 3) check("post_reset_not_early", 64'(obs_rv), 64'd0);
      if (c == 4) check("post_reset_at_lat", 64'(obs_rv), 64'd1);
    end

    // Depth-4 instance: FIFO fills, then a drain allows a same-cycle refill.
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      d2_exe_valid = 1'b1; d2_exe_fmt = TCU_FMT_FP32; d2_exe_mdata = 64'hF0 + 64'(c); d2_res_ready = 1'b0;
      #1;
      if (d2_exe_ready) accepted++;
    end
    check("d4_accepted", 64'(accepted), 64'd4);
    check("d4_head_valid", 64'(d2_res_valid), 64'd1);
    check("d4_enable_low", 64'(d2_fedp_enable), 64'd0);
    @(negedge clk);
    d2_res_ready = 1'b1;
    #1;
    check("d4_refill_ready", 64'(d2_exe_ready), 64'd1);
    check("d4_head_mdata", d2_res_mdata, 64'hF0);
    @(negedge clk);
    d2_exe_valid = 1'b0;
    for (int c = 0; c < 14; c++) @(negedge clk);
    #1;
    check("d4_drained", 64'(d2_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
